// File: rtl/axi4_mst_arbiter.sv
// axi4_mst_arbiter: 2:1 AXI4 master arbiter merging IFU (M0, read-only) and LSU (M1, read/write) onto io_master.
// Ports: i_clk/i_rst_n (async active-low); m0_ar*/m0_r* IFU read channels;
// m1_ar*/m1_r*/m1_aw*/m1_w*/m1_b* LSU channels; io_master_* downstream AXI4 master.
// One transaction in flight at a time; reads round-robin, an LSU write beats an LSU read.
module axi4_mst_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  m0_arvalid,
  input  logic [DATA_W-1:0]     m0_araddr,
  input  logic [7:0]            m0_arlen,
  input  logic [2:0]            m0_arsize,
  input  logic [1:0]            m0_arburst,
  output logic                  m0_arready,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,
  input  logic                  m0_rready,
  input  logic                  m1_arvalid,
  input  logic [DATA_W-1:0]     m1_araddr,
  input  logic [7:0]            m1_arlen,
  input  logic [2:0]            m1_arsize,
  input  logic [1:0]            m1_arburst,
  output logic                  m1_arready,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  input  logic                  m1_rready,
  input  logic                  m1_awvalid,
  input  logic [DATA_W-1:0]     m1_awaddr,
  input  logic [7:0]            m1_awlen,
  input  logic [2:0]            m1_awsize,
  input  logic [1:0]            m1_awburst,
  output logic                  m1_awready,
  input  logic                  m1_wvalid,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  input  logic                  m1_wlast,
  output logic                  m1_wready,
  output logic                  m1_bvalid,
  output logic [1:0]            m1_bresp,
  input  logic                  m1_bready,
  input  logic                  io_master_awready,
  output logic                  io_master_awvalid,
  output logic [3:0]            io_master_awid,
  output logic [DATA_W-1:0]     io_master_awaddr,
  output logic [7:0]            io_master_awlen,
  output logic [2:0]            io_master_awsize,
  output logic [1:0]            io_master_awburst,
  input  logic                  io_master_wready,
  output logic                  io_master_wvalid,
  output logic [DATA_W-1:0]     io_master_wdata,
  output logic [DATA_W/8-1:0]   io_master_wstrb,
  output logic                  io_master_wlast,
  output logic                  io_master_bready,
  input  logic                  io_master_bvalid,
  input  logic [1:0]            io_master_bresp,
  input  logic                  io_master_arready,
  output logic                  io_master_arvalid,
  output logic [3:0]            io_master_arid,
  output logic [DATA_W-1:0]     io_master_araddr,
  output logic [7:0]            io_master_arlen,
  output logic [2:0]            io_master_arsize,
  output logic [1:0]            io_master_arburst,
  output logic                  io_master_rready,
  input  logic                  io_master_rvalid,
  input  logic [1:0]            io_master_rresp,
  input  logic [DATA_W-1:0]     io_master_rdata,
  input  logic                  io_master_rlast
);
  typedef enum logic [1:0] {IDLE, RD_M0, RD_M1, WR_M1} state_t;
  state_t state, state_nxt;
  logic rr_last, ar_done, aw_done, w_done;
  logic rd, sel1, wr, ar_hs, r_end, aw_hs, w_end, b_end;
  assign rd   = (state == RD_M0) | (state == RD_M1);
  assign sel1 = state == RD_M1;
  assign wr   = state == WR_M1;
  // Read path: everything is muxed by the granted reader and gated by state,
  // so outputs fall to zero the moment the async reset forces IDLE.
  assign io_master_arvalid = rd & (sel1 ? m1_arvalid : m0_arvalid) & ~ar_done;
  assign io_master_arid    = {3'd0, sel1};
  assign io_master_araddr  = sel1 ? m1_araddr  : m0_araddr;
  assign io_master_arlen   = sel1 ? m1_arlen   : m0_arlen;
  assign io_master_arsize  = sel1 ? m1_arsize  : m0_arsize;
  assign io_master_arburst = sel1 ? m1_arburst : m0_arburst;
  assign m0_arready        = (state == RD_M0) & io_master_arready & ~ar_done;
  assign m1_arready        = sel1 & io_master_arready & ~ar_done;
  assign ar_hs             = io_master_arvalid & io_master_arready;
  assign io_master_rready  = rd & (sel1 ? m1_rready : m0_rready);
  assign m0_rvalid         = (state == RD_M0) & io_master_rvalid;
  assign m1_rvalid         = sel1 & io_master_rvalid;
  assign m0_rdata          = io_master_rdata;
  assign m1_rdata          = io_master_rdata;
  assign m0_rresp          = io_master_rresp;
  assign m1_rresp          = io_master_rresp;
  assign m0_rlast          = io_master_rlast;
  assign m1_rlast          = io_master_rlast;
  assign r_end             = io_master_rvalid & io_master_rready & io_master_rlast;
  // Write path: AW and W run independently; each is closed by its own done flag.
  assign io_master_awvalid = wr & m1_awvalid & ~aw_done;
  assign io_master_awid    = 4'd1;
  assign io_master_awaddr  = m1_awaddr;
  assign io_master_awlen   = m1_awlen;
  assign io_master_awsize  = m1_awsize;
  assign io_master_awburst = m1_awburst;
  assign m1_awready        = wr & io_master_awready & ~aw_done;
  assign aw_hs             = io_master_awvalid & io_master_awready;
  assign io_master_wvalid  = wr & m1_wvalid & ~w_done;
  assign io_master_wdata   = m1_wdata;
  assign io_master_wstrb   = m1_wstrb;
  assign io_master_wlast   = m1_wlast;
  assign m1_wready         = wr & io_master_wready & ~w_done;
  assign w_end             = io_master_wvalid & io_master_wready & m1_wlast;
  assign io_master_bready  = wr & m1_bready;
  assign m1_bvalid         = wr & io_master_bvalid;
  assign m1_bresp          = io_master_bresp;
  assign b_end             = io_master_bvalid & io_master_bready;
  // rr_last = 1 means M1 was the last reader, so a tie goes to M0.
  always_comb begin
    state_nxt = state;
    if (state == IDLE)
      state_nxt = m1_awvalid                ? WR_M1 :
                  (m0_arvalid & m1_arvalid) ? (rr_last ? RD_M0 : RD_M1) :
                  m0_arvalid                ? RD_M0 :
                  m1_arvalid                ? RD_M1 : IDLE;
    else if ((rd & r_end) | (wr & b_end))
      state_nxt = IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rr_last <= (state == IDLE && state_nxt == RD_M0) ? 1'b0 :
                 (state == IDLE && state_nxt == RD_M1) ? 1'b1 : rr_last;
      ar_done <= rd & ~r_end & (ar_done | ar_hs);
      aw_done <= wr & ~b_end & (aw_done | aw_hs);
      w_done  <= wr & ~b_end & (w_done | w_end);
    end
  end
endmodule

// File: tb/tb_axi4_mst_arbiter.sv
// tb_axi4_mst_arbiter: directed bench with a transaction-level ownership model checked every cycle.
module tb_axi4_mst_arbiter;
  localparam int W = 32;
  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;
  logic [W-1:0] m0_araddr, m0_rdata;
  logic [7:0] m0_arlen;
  logic [2:0] m0_arsize;
  logic [1:0] m0_arburst, m0_rresp;
  logic m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready;
  logic [W-1:0] m1_araddr, m1_rdata;
  logic [7:0] m1_arlen;
  logic [2:0] m1_arsize;
  logic [1:0] m1_arburst, m1_rresp;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wlast, m1_wready, m1_bvalid, m1_bready;
  logic [W-1:0] m1_awaddr, m1_wdata;
  logic [7:0] m1_awlen;
  logic [2:0] m1_awsize;
  logic [1:0] m1_awburst, m1_bresp;
  logic [W/8-1:0] m1_wstrb;
  logic io_master_awready, io_master_awvalid, io_master_wready, io_master_wvalid, io_master_wlast;
  logic [3:0] io_master_awid, io_master_arid;
  logic [W-1:0] io_master_awaddr, io_master_wdata, io_master_araddr, io_master_rdata;
  logic [7:0] io_master_awlen, io_master_arlen;
  logic [2:0] io_master_awsize, io_master_arsize;
  logic [1:0] io_master_awburst, io_master_arburst, io_master_bresp, io_master_rresp;
  logic [W/8-1:0] io_master_wstrb;
  logic io_master_bready, io_master_bvalid, io_master_arready, io_master_arvalid;
  logic io_master_rready, io_master_rvalid, io_master_rlast;

  axi4_mst_arbiter #(.DATA_W(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arready(m0_arready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arready(m1_arready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rready(m1_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
    .m1_awburst(m1_awburst), .m1_awready(m1_awready), .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wready(m1_wready), .m1_bvalid(m1_bvalid),
    .m1_bresp(m1_bresp), .m1_bready(m1_bready),
    .io_master_awready(io_master_awready), .io_master_awvalid(io_master_awvalid),
    .io_master_awid(io_master_awid), .io_master_awaddr(io_master_awaddr),
    .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
    .io_master_awburst(io_master_awburst), .io_master_wready(io_master_wready),
    .io_master_wvalid(io_master_wvalid), .io_master_wdata(io_master_wdata),
    .io_master_wstrb(io_master_wstrb), .io_master_wlast(io_master_wlast),
    .io_master_bready(io_master_bready), .io_master_bvalid(io_master_bvalid),
    .io_master_bresp(io_master_bresp), .io_master_arready(io_master_arready),
    .io_master_arvalid(io_master_arvalid), .io_master_arid(io_master_arid),
    .io_master_araddr(io_master_araddr), .io_master_arlen(io_master_arlen),
    .io_master_arsize(io_master_arsize), .io_master_arburst(io_master_arburst),
    .io_master_rready(io_master_rready), .io_master_rvalid(io_master_rvalid),
    .io_master_rresp(io_master_rresp), .io_master_rdata(io_master_rdata),
    .io_master_rlast(io_master_rlast)
  );

  always #5 i_clk = ~i_clk;

  int chk_cnt = 0, pass_cnt = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic timeout(input string name);
    chk_cnt++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic logic [11:0] ctl_now();
    return {io_master_arvalid, m0_arready, m1_arready, io_master_rready, m0_rvalid, m1_rvalid,
            io_master_awvalid, m1_awready, io_master_wvalid, m1_wready, io_master_bready, m1_bvalid};
  endfunction

  // Model: owner of the downstream port (-1 none, 0/1 reader, 2 LSU writer),
  // which reader went last, and which channel phases of the current transaction are finished.
  int owner = -1;
  bit last_m1 = 1'b1, ar_seen, aw_seen, w_seen;
  bit e_arv, e_ar0, e_ar1, e_rr, e_rv0, e_rv1, e_awv, e_awr, e_wv, e_wr, e_br, e_bv;
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      owner = -1; last_m1 = 1'b1; ar_seen = 0; aw_seen = 0; w_seen = 0;
      check("ctl_in_reset", ctl_now(), 12'd0);
    end else begin
      e_arv = (owner == 0 && m0_arvalid && !ar_seen) || (owner == 1 && m1_arvalid && !ar_seen);
      e_ar0 = owner == 0 && io_master_arready && !ar_seen;
      e_ar1 = owner == 1 && io_master_arready && !ar_seen;
      e_rr  = (owner == 0 && m0_rready) || (owner == 1 && m1_rready);
      e_rv0 = owner == 0 && io_master_rvalid;
      e_rv1 = owner == 1 && io_master_rvalid;
      e_awv = owner == 2 && m1_awvalid && !aw_seen;
      e_awr = owner == 2 && io_master_awready && !aw_seen;
      e_wv  = owner == 2 && m1_wvalid && !w_seen;
      e_wr  = owner == 2 && io_master_wready && !w_seen;
      e_br  = owner == 2 && m1_bready;
      e_bv  = owner == 2 && io_master_bvalid;
      check("ctl", ctl_now(), {e_arv, e_ar0, e_ar1, e_rr, e_rv0, e_rv1, e_awv, e_awr, e_wv, e_wr, e_br, e_bv});
      if (e_arv) begin
        check("arid", io_master_arid, owner);
        check("araddr", io_master_araddr, owner == 1 ? m1_araddr : m0_araddr);
        check("arlen", io_master_arlen, owner == 1 ? m1_arlen : m0_arlen);
      end
      if (e_rv0 || e_rv1)
        check("rdata_route", e_rv1 ? {m1_rresp, m1_rlast, m1_rdata} : {m0_rresp, m0_rlast, m0_rdata},
              {io_master_rresp, io_master_rlast, io_master_rdata});
      if (e_awv) check("aw_fields", {io_master_awid, io_master_awaddr, io_master_awlen},
                       {4'd1, m1_awaddr, m1_awlen});
      if (e_wv) check("w_fields", {io_master_wstrb, io_master_wlast, io_master_wdata},
                      {m1_wstrb, m1_wlast, m1_wdata});
      if (e_bv) check("bresp", m1_bresp, io_master_bresp);
      if (owner < 0) begin
        if (m1_awvalid) owner = 2;
        else if (m0_arvalid && m1_arvalid) owner = last_m1 ? 0 : 1;
        else if (m0_arvalid) owner = 0;
        else if (m1_arvalid) owner = 1;
        if (owner == 0 || owner == 1) last_m1 = owner == 1;
      end else if (owner != 2) begin
        if (e_arv && io_master_arready) ar_seen = 1;
        if (io_master_rvalid && e_rr && io_master_rlast) begin owner = -1; ar_seen = 0; end
      end else begin
        if (e_awv && io_master_awready) aw_seen = 1;
        if (e_wv && io_master_wready && m1_wlast) w_seen = 1;
        if (io_master_bvalid && e_br) begin owner = -1; aw_seen = 0; w_seen = 0; end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic clear_inputs();
    m0_arvalid = 0; m0_araddr = '0; m0_arlen = '0; m0_arsize = 3'd2; m0_arburst = 2'd1; m0_rready = 1;
    m1_arvalid = 0; m1_araddr = '0; m1_arlen = '0; m1_arsize = 3'd2; m1_arburst = 2'd1; m1_rready = 1;
    m1_awvalid = 0; m1_awaddr = '0; m1_awlen = '0; m1_awsize = 3'd2; m1_awburst = 2'd1;
    m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0; m1_bready = 1;
    io_master_awready = 0; io_master_wready = 0; io_master_bvalid = 0; io_master_bresp = 0;
    io_master_arready = 0; io_master_rvalid = 0; io_master_rresp = 0; io_master_rdata = '0; io_master_rlast = 0;
  endtask

  task automatic do_reset();
    i_rst_n = 0;
    clear_inputs();
    repeat (2) tick();
    i_rst_n = 1;
    tick();
  endtask

  logic [W-1:0] rx_q[$];
  logic [1:0] rv_q[$];

  task automatic serve_read(input int beats, input logic [W-1:0] base, input logic [1:0] resp,
                            input bit toggle, output int gid);
    int n;
    bit hs;
    n = 0;
    while (!io_master_arvalid && n < 50) begin tick(); n++; end
    if (!io_master_arvalid) begin timeout("ar_wait"); gid = -1; return; end
    gid = int'(io_master_arid);
    io_master_arready = 1;
    tick();
    io_master_arready = 0;
    if (gid == 0) m0_arvalid = 0; else m1_arvalid = 0;
    for (int i = 0; i < beats; i++) begin
      io_master_rvalid = 1; io_master_rdata = base + W'(i); io_master_rresp = resp;
      io_master_rlast = i == beats - 1;
      n = 0;
      do begin
        if (toggle) begin m0_rready = ~m0_rready; m1_rready = ~m1_rready; end
        #1;
        hs = io_master_rready;
        if (hs) begin
          rx_q.push_back(m0_rvalid ? m0_rdata : m1_rdata);
          rv_q.push_back({m0_rvalid, m1_rvalid});
        end
        @(posedge i_clk); #1;
        n++;
      end while (!hs && n < 50);
      if (!hs) timeout("r_wait");
    end
    io_master_rvalid = 0; io_master_rlast = 0;
    m0_rready = 1; m1_rready = 1;
  endtask

  task automatic serve_write(input bit w_first, input logic [1:0] resp, output logic [1:0] got);
    int n;
    n = 0;
    while (!io_master_awvalid && n < 50) begin tick(); n++; end
    if (!io_master_awvalid) begin timeout("aw_wait"); got = 2'bxx; return; end
    check("awid", io_master_awid, 4'd1);
    if (!w_first) begin
      io_master_awready = 1; tick(); io_master_awready = 0; m1_awvalid = 0;
    end
    check("wstrb", io_master_wstrb, 4'hF);
    io_master_wready = 1;
    tick();
    m1_wvalid = 0;
    check("no_wready_after_wlast", m1_wready, 1'b0);
    io_master_wready = 0;
    if (w_first) begin
      io_master_awready = 1; tick(); io_master_awready = 0; m1_awvalid = 0;
    end
    io_master_bvalid = 1; io_master_bresp = resp;
    #1;
    got = m1_bresp;
    check("m1_bvalid", m1_bvalid, 1'b1);
    @(posedge i_clk); #1;
    io_master_bvalid = 0;
  endtask

  initial begin
    int gid;
    int gq[$];
    logic [1:0] br;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gid;
    int gq[$];
    logic [1:0] br;
    clear_inputs();
    do_reset();
    // 1: single IFU read
    m0_araddr = 32'h3000_0000; m0_arlen = 0; m0_arvalid = 1;
    #1;
    check("t1_no_arvalid_same_cycle", io_master_arvalid, 1'b0);
    @(posedge i_clk); #1;
    check("t1_arvalid_next_cycle", io_master_arvalid, 1'b1);
    check("t1_arid", io_master_arid, 4'd0);
    check("t1_araddr", io_master_araddr, 32'h3000_0000);
    rx_q.delete(); rv_q.delete();
    serve_read(1, 32'hDEADBEEF, 2'b00, 0, gid);
    check("t1_rdata", rx_q.size() > 0 ? rx_q[0] : 32'h0, 32'hDEADBEEF);
    check("t1_rvalid_route", rv_q.size() > 0 ? rv_q[0] : 2'b00, 2'b10);
    check("t1_idle_after", io_master_rready, 1'b0);
    // 2: three contended rounds after reset
    do_reset();
    m0_araddr = 32'h100; m1_araddr = 32'h200; m0_arvalid = 1; m1_arvalid = 1;
    for (int k = 0; k < 4; k++) begin
      serve_read(1, W'(k), 2'b00, 0, gid);
      gq.push_back(gid);
      if (k < 2) begin
        if (!m0_arvalid) m0_arvalid = 1;
        if (!m1_arvalid) m1_arvalid = 1;
      end
    end
    check("t2_grant0", gq[0], 0);
    check("t2_grant1", gq[1], 1);
    check("t2_grant2", gq[2], 0);
    check("t2_grant3", gq[3], 1);
    // 3: LSU write and read together, write goes first
    m1_awaddr = 32'h8000_0010; m1_awvalid = 1;
    m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF; m1_wlast = 1; m1_wvalid = 1;
    m1_araddr = 32'h8000_0020; m1_arvalid = 1;
    serve_write(0, 2'b00, br);
    check("t3_bresp_okay", br, 2'b00);
    serve_read(1, 32'h55, 2'b00, 0, gid);
    check("t3_read_after_write", gid, 1);
    // 4: burst of 4 to M1 with rready toggling
    m1_araddr = 32'h8000_1000; m1_arlen = 3; m1_arvalid = 1;
    rx_q.delete(); rv_q.delete();
    serve_read(4, 32'hA0, 2'b00, 1, gid);
    check("t4_beats", rx_q.size(), 4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) check("t4_beat_data", rx_q[i], 32'hA0 + i);
    check("t4_idle_after", io_master_rready, 1'b0);
    m1_arlen = 0;
    // 5: W leads AW by two cycles, SLVERR response
    m1_wdata = 32'hCAFE_0001; m1_wstrb = 4'hF; m1_wlast = 1; m1_wvalid = 1;
    tick(); tick();
    check("t5_w_blocked_in_idle", io_master_wvalid, 1'b0);
    m1_awaddr = 32'h8000_0040; m1_awvalid = 1;
    serve_write(1, 2'b10, br);
    check("t5_bresp_slverr", br, 2'b10);
    check("t5_idle_after", io_master_bready, 1'b0);
    // 6: async reset on beat 2 of a 4-beat IFU read
    m0_araddr = 32'h3000_0100; m0_arlen = 3; m0_arvalid = 1;
    tick();
    io_master_arready = 1; tick(); io_master_arready = 0; m0_arvalid = 0;
    io_master_rvalid = 1; io_master_rdata = 32'h0; io_master_rlast = 0;
    tick();
    io_master_rdata = 32'h1;
    #1;
    check("t6_rready_before_reset", io_master_rready, 1'b1);
    i_rst_n = 0;
    #1;
    check("t6_valids_zero", ctl_now(), 12'd0);
    clear_inputs();
    tick();
    i_rst_n = 1;
    tick();
    m0_arlen = 0; m0_arvalid = 1; m1_arvalid = 1;
    serve_read(1, 32'h77, 2'b00, 0, gid);
    check("t6_rr_reset_to_m1", gid, 0);
    serve_read(1, 32'h78, 2'b00, 0, gid);
    check("t6_m1_follows", gid, 1);
    tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
